// File: rtl/htif_in_arbiter.sv
// Packet-granular round-robin arbiter for the shared host-to-target HTIF channel.
// A FIFO of grant indices steers each target-to-host response packet back to its requester.
module htif_in_arbiter #(
    parameter int N_REQ       = 2,
    parameter int HTIF_WIDTH  = 16,
    parameter int ORDER_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*HTIF_WIDTH-1:0]   req_bits,
    input  logic [N_REQ-1:0]              req_last,
    output logic                          htif_in_valid,
    input  logic                          htif_in_ready,
    output logic [HTIF_WIDTH-1:0]         htif_in_bits,
    input  logic                          htif_out_valid,
    output logic                          htif_out_ready,
    input  logic [HTIF_WIDTH-1:0]         htif_out_bits,
    input  logic                          htif_out_last,
    output logic [N_REQ-1:0]              rsp_valid,
    input  logic [N_REQ-1:0]              rsp_ready,
    output logic [HTIF_WIDTH-1:0]         rsp_bits,
    output logic                          rsp_last,
    output logic [$clog2(ORDER_DEPTH):0]  outstanding,
    output logic                          busy
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW = $clog2(ORDER_DEPTH);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW:0]     wr_ptr_q, rd_ptr_q;
    logic [GW-1:0]   order_mem [ORDER_DEPTH];

    logic            fifo_empty, fifo_full;
    logic            push, pop, last_fire;
    logic [GW-1:0]   head, pick, grant_inc;
    logic            pick_found;
    int              rr_idx;

    logic [HTIF_WIDTH-1:0] req_beat [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign req_beat[gi] = req_bits[gi*HTIF_WIDTH +: HTIF_WIDTH];
    end

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign head       = order_mem[rd_ptr_q[PW-1:0]];

    // Descending scan so the lowest offset from rr_ptr wins.
    always_comb begin
        pick       = rr_ptr_q;
        pick_found = 1'b0;
        rr_idx     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            rr_idx = int'(rr_ptr_q) + k;
            if (rr_idx >= N_REQ) rr_idx = rr_idx - N_REQ;
            if (req_valid[rr_idx]) begin
                pick       = rr_idx[GW-1:0];
                pick_found = 1'b1;
            end
        end
    end

    assign grant_inc = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
    assign last_fire = (state_q == LOCKED) && req_valid[grant_q] &&
                       htif_in_ready && req_last[grant_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_q + {{PW{1'b0}}, push};
            rd_ptr_q <= rd_ptr_q + {{PW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) order_mem[wr_ptr_q[PW-1:0]] <= pick;
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        push     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found && !fifo_full) begin
                    grant_d = pick;
                    push    = 1'b1;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (last_fire) begin
                    state_d  = IDLE;
                    rr_ptr_d = grant_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready     = '0;
        htif_in_valid = 1'b0;
        htif_in_bits  = req_beat[grant_q];
        if (state_q == LOCKED) begin
            htif_in_valid      = req_valid[grant_q];
            req_ready[grant_q] = htif_in_ready;
        end
    end

    always_comb begin
        rsp_valid      = '0;
        htif_out_ready = 1'b0;
        if (!fifo_empty) begin
            rsp_valid[head] = htif_out_valid;
            htif_out_ready  = rsp_ready[head];
        end
    end

    assign rsp_bits    = htif_out_bits;
    assign rsp_last    = htif_out_last;
    assign pop         = htif_out_valid && htif_out_ready && htif_out_last;
    assign outstanding = wr_ptr_q - rd_ptr_q;
    assign busy        = (state_q == LOCKED);

endmodule

// File: tb/tb_htif_in_arbiter.sv
// Scenario bench for htif_in_arbiter: directed and randomized traffic checked against a
// round-robin packet-order model and an in-order response routing model.
module tb_htif_in_arbiter;

    localparam int N  = 2;
    localparam int W  = 16;
    localparam int D  = 4;
    localparam int OW = $clog2(D) + 1;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req_valid = '0, req_ready, req_last = '0;
    logic [N*W-1:0] req_bits = '0;
    logic           htif_in_valid, htif_in_ready = 1'b0;
    logic [W-1:0]   htif_in_bits;
    logic           htif_out_valid = 1'b0, htif_out_ready, htif_out_last = 1'b0;
    logic [W-1:0]   htif_out_bits = '0;
    logic [N-1:0]   rsp_valid, rsp_ready = '0;
    logic [W-1:0]   rsp_bits;
    logic           rsp_last;
    logic [OW-1:0]  outstanding;
    logic           busy;

    htif_in_arbiter #(.N_REQ(N), .HTIF_WIDTH(W), .ORDER_DEPTH(D)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_bits(req_bits), .req_last(req_last),
        .htif_in_valid(htif_in_valid), .htif_in_ready(htif_in_ready), .htif_in_bits(htif_in_bits),
        .htif_out_valid(htif_out_valid), .htif_out_ready(htif_out_ready),
        .htif_out_bits(htif_out_bits), .htif_out_last(htif_out_last),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_bits(rsp_bits), .rsp_last(rsp_last),
        .outstanding(outstanding), .busy(busy)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0, total_cnt = 0;
    int cyc = 0;

    // Request beat: [15:13] owner, [12] last-of-packet, [11:0] payload.
    logic [W-1:0] src_q [N][$];
    logic [W-1:0] mdl_beats [N][$];
    int           mdl_len [N][$];
    logic [W-1:0] exp_stream[$];
    int           exp_owner[$];
    logic [W:0]   rsp_pend[$];
    logic [W:0]   exp_rsp[$];
    int           rsp_len_q[$];
    logic [W-1:0] obs_in_data[$];
    int           obs_in_cyc[$];
    logic [N-1:0] obs_rsp_vec[$];
    logic [W:0]   obs_rsp_word[$];
    int           in_last_seen, rsp_done, max_out;
    bit           hold_rsp, rnd_mode;

    task automatic add_pkt(input int r, input int len);
        logic [W-1:0] w;
        for (int b = 0; b < len; b++) begin
            w = {3'(r), 1'(b == len - 1), 12'($urandom)};
            src_q[r].push_back(w);
            mdl_beats[r].push_back(w);
        end
        mdl_len[r].push_back(len);
    endtask

    // Every requester holds its packets pending from the start, so the order is plain
    // round-robin over requesters that still have packets left.
    task automatic build_expect();
        int rem [N];
        int ptr, left, o, len, r;
        exp_stream.delete();
        exp_owner.delete();
        left = 0;
        for (int i = 0; i < N; i++) begin
            rem[i] = mdl_len[i].size();
            left += rem[i];
        end
        ptr = 0;
        while (left > 0) begin
            o = -1;
            for (int k = 0; k < N; k++) begin
                r = (ptr + k) % N;
                if (o < 0 && rem[r] > 0) o = r;
            end
            rem[o]--;
            left--;
            exp_owner.push_back(o);
            ptr = (o + 1) % N;
            len = mdl_len[o].pop_front();
            for (int b = 0; b < len; b++) exp_stream.push_back(mdl_beats[o].pop_front());
        end
    endtask

    task automatic drive_req();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_bits[i*W +: W] = src_q[i][0];
                req_last[i]        = src_q[i][0][12];
            end else begin
                req_valid[i]       = 1'b0;
                req_bits[i*W +: W] = '0;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_valid = '0; req_last = '0; req_bits = '0;
        htif_in_ready = 1'b1; htif_out_valid = 1'b0; htif_out_bits = '0; htif_out_last = 1'b0;
        rsp_ready = '1;
        for (int i = 0; i < N; i++) begin
            src_q[i].delete(); mdl_beats[i].delete(); mdl_len[i].delete();
        end
        exp_stream.delete(); exp_owner.delete(); rsp_pend.delete(); exp_rsp.delete();
        rsp_len_q.delete(); obs_in_data.delete(); obs_in_cyc.delete();
        obs_rsp_vec.delete(); obs_rsp_word.delete();
        in_last_seen = 0; rsp_done = 0; max_out = 0; hold_rsp = 1'b0; rnd_mode = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Acts as host sources plus the target: records htif_in beats and answers each complete
    // request packet with a response packet, strictly in order.
    task automatic run_traffic(input int tgt_in, input int tgt_rsp, input int budget,
                               output bit timed_out);
        int           c, len;
        logic         in_fire, out_fire;
        logic [W-1:0] in_data;
        logic [N-1:0] fired, rvec;
        logic [W:0]   rword, w;
        c = 0;
        while ((in_last_seen < tgt_in || rsp_done < tgt_rsp) && c < budget) begin
            drive_req();
            htif_in_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (!hold_rsp && rsp_pend.size() > 0 && (!rnd_mode || $urandom_range(0, 2) != 0)) begin
                htif_out_valid = 1'b1;
                htif_out_bits  = rsp_pend[0][W-1:0];
                htif_out_last  = rsp_pend[0][W];
            end else begin
                htif_out_valid = 1'b0;
                htif_out_bits  = '0;
                htif_out_last  = 1'b0;
            end
            rsp_ready = rnd_mode ? N'($urandom) : '1;
            @(negedge clk);
            fired    = req_valid & req_ready;
            in_fire  = htif_in_valid & htif_in_ready;
            in_data  = htif_in_bits;
            out_fire = htif_out_valid & htif_out_ready;
            rvec     = rsp_valid;
            rword    = {rsp_last, rsp_bits};
            if (int'(outstanding) > max_out) max_out = int'(outstanding);
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) if (fired[i]) void'(src_q[i].pop_front());
            if (in_fire) begin
                obs_in_data.push_back(in_data);
                obs_in_cyc.push_back(cyc);
                if (in_data[12]) begin
                    in_last_seen++;
                    len = (rsp_len_q.size() > 0) ? rsp_len_q.pop_front() : $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) begin
                        w = {1'(b == len - 1), W'($urandom)};
                        rsp_pend.push_back(w);
                        exp_rsp.push_back(w);
                    end
                end
            end
            if (out_fire) begin
                obs_rsp_vec.push_back(rvec);
                obs_rsp_word.push_back(rword);
                if (rsp_pend[0][W]) rsp_done++;
                void'(rsp_pend.pop_front());
            end
            cyc++;
            c++;
        end
        timed_out = (in_last_seen < tgt_in || rsp_done < tgt_rsp);
        drive_req();
        htif_in_ready = 1'b1; htif_out_valid = 1'b0; htif_out_bits = '0; htif_out_last = 1'b0;
        rsp_ready = '1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req_valid = 2'b11; req_last = 2'b00;
        req_bits = {16'hB5A5, 16'h1234};
        htif_in_ready = 1'b1; htif_out_valid = 1'b1; htif_out_last = 1'b1; rsp_ready = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({req_ready, htif_in_valid, htif_out_ready, rsp_valid, busy} !== 7'b0)
            $display("FAIL reset_outputs: got %b want 0",
                     {req_ready, htif_in_valid, htif_out_ready, rsp_valid, busy});
        else pass_cnt++;
        total_cnt++;
        if (outstanding !== '0) $display("FAIL reset_outstanding: got %0d want 0", outstanding);
        else pass_cnt++;
        htif_out_valid = 1'b0;
        reset_n = 1'b1;
        #1;
        total_cnt++;
        if ({busy, req_ready} !== 3'b000) $display("FAIL reset_bubble: got %b want 000", {busy, req_ready});
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL reset_busy_after_grant: got %b want 1", busy);
        else pass_cnt++;
        total_cnt++;
        if (outstanding !== OW'(1)) $display("FAIL reset_first_push: got %0d want 1", outstanding);
        else pass_cnt++;
        total_cnt++;
        if (req_ready !== 2'b01) $display("FAIL reset_first_grant: got %b want 01", req_ready);
        else pass_cnt++;
        total_cnt++;
        if ({htif_in_valid, htif_in_bits} !== {1'b1, 16'h1234})
            $display("FAIL reset_first_beat: got %b/%h want 1/1234", htif_in_valid, htif_in_bits);
        else pass_cnt++;
    endtask

    task automatic test_contention();
        bit to;
        int n, gap;
        do_reset();
        add_pkt(0, 3); add_pkt(1, 3); add_pkt(0, 3);
        build_expect();
        hold_rsp = 1'b1;
        run_traffic(2, 0, 200, to);
        total_cnt++;
        if (to || outstanding !== OW'(2))
            $display("FAIL contention_outstanding2: got %0d (timeout %0d) want 2", outstanding, to);
        else pass_cnt++;
        run_traffic(3, 0, 200, to);
        total_cnt++;
        if (to || outstanding !== OW'(3))
            $display("FAIL contention_outstanding3: got %0d (timeout %0d) want 3", outstanding, to);
        else pass_cnt++;
        total_cnt++;
        if (obs_in_data.size() !== exp_stream.size())
            $display("FAIL contention_beat_count: got %0d want %0d", obs_in_data.size(), exp_stream.size());
        else pass_cnt++;
        n = (obs_in_data.size() < exp_stream.size()) ? obs_in_data.size() : exp_stream.size();
        for (int k = 0; k < n; k++) begin
            total_cnt++;
            if (obs_in_data[k] !== exp_stream[k])
                $display("FAIL contention_beat%0d: got %h want %h", k, obs_in_data[k], exp_stream[k]);
            else pass_cnt++;
            if (k > 0) begin
                gap = exp_stream[k-1][12] ? 2 : 1;
                total_cnt++;
                if (obs_in_cyc[k] - obs_in_cyc[k-1] !== gap)
                    $display("FAIL contention_spacing%0d: got %0d want %0d", k,
                             obs_in_cyc[k] - obs_in_cyc[k-1], gap);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_round_robin();
        bit to;
        int pk, n;
        logic [N-1:0] ev;
        do_reset();
        for (int p = 0; p < 4; p++) begin add_pkt(0, 1); add_pkt(1, 1); end
        build_expect();
        run_traffic(8, 8, 400, to);
        total_cnt++;
        if (to) $display("FAIL rr_timeout: got %0d/%0d packets want 8/8", in_last_seen, rsp_done);
        else pass_cnt++;
        n = (obs_in_data.size() < exp_stream.size()) ? obs_in_data.size() : exp_stream.size();
        for (int k = 0; k < n; k++) begin
            total_cnt++;
            if (obs_in_data[k] !== exp_stream[k] || exp_owner[k] !== k % 2)
                $display("FAIL rr_grant%0d: got %h want %h (owner %0d)", k, obs_in_data[k],
                         exp_stream[k], exp_owner[k]);
            else pass_cnt++;
        end
        pk = 0;
        for (int k = 0; k < obs_rsp_vec.size() && pk < exp_owner.size() && k < exp_rsp.size(); k++) begin
            ev = N'(1) << exp_owner[pk];
            total_cnt++;
            if (obs_rsp_vec[k] !== ev || obs_rsp_word[k] !== exp_rsp[k])
                $display("FAIL rr_rsp%0d: got %b/%h want %b/%h", k, obs_rsp_vec[k], obs_rsp_word[k],
                         ev, exp_rsp[k]);
            else pass_cnt++;
            if (exp_rsp[k][W]) pk++;
        end
    endtask

    task automatic test_response_steering();
        bit to;
        do_reset();
        add_pkt(0, 1); add_pkt(1, 1);
        rsp_len_q.push_back(2); rsp_len_q.push_back(1);
        hold_rsp = 1'b1;
        run_traffic(2, 0, 100, to);
        total_cnt++;
        if (to || outstanding !== OW'(2) || rsp_pend.size() !== 3)
            $display("FAIL steer_setup: got %0d outstanding %0d beats want 2 and 3", outstanding, rsp_pend.size());
        else pass_cnt++;
        htif_out_valid = 1'b1; htif_out_bits = rsp_pend[0][W-1:0]; htif_out_last = rsp_pend[0][W];
        rsp_ready = 2'b10;
        @(negedge clk);
        total_cnt++;
        if ({rsp_valid, htif_out_ready} !== 3'b010)
            $display("FAIL steer_stall: got %b want 010", {rsp_valid, htif_out_ready});
        else pass_cnt++;
        @(posedge clk);
        #1;
        rsp_ready = 2'b11;
        for (int b = 0; b < 3; b++) begin
            htif_out_bits = rsp_pend[0][W-1:0]; htif_out_last = rsp_pend[0][W];
            @(negedge clk);
            total_cnt++;
            if ({rsp_valid, htif_out_ready, rsp_last, rsp_bits} !== {(b < 2) ? 2'b01 : 2'b10, 1'b1, rsp_pend[0]})
                $display("FAIL steer_beat%0d: got %b/%b/%h want %b/1/%h", b, rsp_valid, htif_out_ready,
                         {rsp_last, rsp_bits}, (b < 2) ? 2'b01 : 2'b10, rsp_pend[0]);
            else pass_cnt++;
            @(posedge clk);
            #1;
            void'(rsp_pend.pop_front());
            total_cnt++;
            if (outstanding !== OW'((b == 0) ? 2 : (b == 1) ? 1 : 0))
                $display("FAIL steer_outstanding%0d: got %0d want %0d", b, outstanding,
                         (b == 0) ? 2 : (b == 1) ? 1 : 0);
            else pass_cnt++;
        end
        htif_out_bits = W'($urandom); htif_out_last = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({rsp_valid, htif_out_ready} !== 3'b000)
            $display("FAIL steer_empty: got %b want 000", {rsp_valid, htif_out_ready});
        else pass_cnt++;
        @(posedge clk);
        #1;
        htif_out_valid = 1'b0;
    endtask

    task automatic test_fifo_full();
        bit to;
        do_reset();
        for (int p = 0; p < 5; p++) begin add_pkt(0, 1); rsp_len_q.push_back(1); end
        hold_rsp = 1'b1;
        run_traffic(4, 0, 200, to);
        total_cnt++;
        if (to || src_q[0].size() !== 1) $display("FAIL full_setup: got timeout %0d left %0d want 0/1", to, src_q[0].size());
        else pass_cnt++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total_cnt++;
            if ({busy, req_ready, htif_in_valid, outstanding} !== {4'b0000, OW'(4)})
                $display("FAIL full_no_grant%0d: got busy %b rdy %b val %b out %0d want 0/00/0/4",
                         c, busy, req_ready, htif_in_valid, outstanding);
            else pass_cnt++;
            @(posedge clk);
            #1;
        end
        htif_out_valid = 1'b1; htif_out_bits = rsp_pend[0][W-1:0]; htif_out_last = rsp_pend[0][W];
        @(negedge clk);
        total_cnt++;
        if (rsp_valid !== 2'b01) $display("FAIL full_pop_valid: got %b want 01", rsp_valid);
        else pass_cnt++;
        @(posedge clk);
        #1;
        void'(rsp_pend.pop_front());
        total_cnt++;
        if ({busy, outstanding} !== {1'b0, OW'(3)})
            $display("FAIL full_after_pop: got busy %b out %0d want 0/3", busy, outstanding);
        else pass_cnt++;
        htif_out_bits = rsp_pend[0][W-1:0]; htif_out_last = rsp_pend[0][W];
        @(posedge clk);
        #1;
        void'(rsp_pend.pop_front());
        total_cnt++;
        if ({busy, outstanding} !== {1'b1, OW'(3)})
            $display("FAIL full_push_pop: got busy %b out %0d want 1/3", busy, outstanding);
        else pass_cnt++;
        htif_out_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({htif_in_valid, req_ready, htif_in_bits} !== {1'b1, 2'b01, src_q[0][0]})
            $display("FAIL full_late_beat: got %b/%b/%h want 1/01/%h", htif_in_valid, req_ready,
                     htif_in_bits, src_q[0][0]);
        else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_packet();
        bit to;
        do_reset();
        add_pkt(0, 1);
        hold_rsp = 1'b1;
        run_traffic(1, 0, 50, to);
        add_pkt(1, 3);
        drive_req();
        @(posedge clk);
        #1;
        @(negedge clk);
        total_cnt++;
        if ({busy, htif_in_valid, htif_in_bits} !== {2'b11, src_q[1][0]})
            $display("FAIL mid_first_beat: got %b/%b/%h want 1/1/%h", busy, htif_in_valid, htif_in_bits, src_q[1][0]);
        else pass_cnt++;
        @(posedge clk);
        #1;
        void'(src_q[1].pop_front());
        drive_req();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({htif_in_valid, busy, req_ready, outstanding} !== {4'b0000, OW'(0)})
            $display("FAIL mid_async_drop: got val %b busy %b rdy %b out %0d want all 0",
                     htif_in_valid, busy, req_ready, outstanding);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) src_q[i].delete();
        add_pkt(0, 1); add_pkt(1, 1);
        drive_req();
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({req_ready, htif_in_bits, outstanding} !== {2'b01, src_q[0][0], OW'(1)})
            $display("FAIL mid_restart: got %b/%h/%0d want 01/%h/1", req_ready, htif_in_bits,
                     outstanding, src_q[0][0]);
        else pass_cnt++;
    endtask

    task automatic test_random();
        bit to;
        int tot, pk, n;
        logic [N-1:0] ev;
        for (int it = 0; it < 3; it++) begin
            do_reset();
            rnd_mode = 1'b1;
            tot = 0;
            for (int r = 0; r < N; r++) begin
                n = $urandom_range(1, 6);
                for (int p = 0; p < n; p++) add_pkt(r, $urandom_range(1, 4));
                tot += n;
            end
            build_expect();
            run_traffic(tot, tot, 4000, to);
            total_cnt++;
            if (to || obs_in_data.size() !== exp_stream.size() || obs_rsp_word.size() !== exp_rsp.size())
                $display("FAIL rand%0d_counts: got %0d beats %0d rsp (timeout %0d) want %0d/%0d", it,
                         obs_in_data.size(), obs_rsp_word.size(), to, exp_stream.size(), exp_rsp.size());
            else pass_cnt++;
            total_cnt++;
            if (max_out > D) $display("FAIL rand%0d_occupancy: got %0d want <= %0d", it, max_out, D);
            else pass_cnt++;
            n = (obs_in_data.size() < exp_stream.size()) ? obs_in_data.size() : exp_stream.size();
            for (int k = 0; k < n; k++) begin
                total_cnt++;
                if (obs_in_data[k] !== exp_stream[k])
                    $display("FAIL rand%0d_beat%0d: got %h want %h", it, k, obs_in_data[k], exp_stream[k]);
                else pass_cnt++;
            end
            pk = 0;
            for (int k = 0; k < obs_rsp_vec.size() && pk < exp_owner.size() && k < exp_rsp.size(); k++) begin
                ev = N'(1) << exp_owner[pk];
                total_cnt++;
                if (obs_rsp_vec[k] !== ev || obs_rsp_word[k] !== exp_rsp[k])
                    $display("FAIL rand%0d_rsp%0d: got %b/%h want %b/%h", it, k, obs_rsp_vec[k],
                             obs_rsp_word[k], ev, exp_rsp[k]);
                else pass_cnt++;
                if (exp_rsp[k][W]) pk++;
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_contention();
        test_round_robin();
        test_response_steering();
        test_fifo_full();
        test_reset_mid_packet();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
